// File: rtl/pl_ex_rns_if.sv
// Handshake and data bus of the RNS execute unit.
// master drives the operation; slave is the execute unit.
interface pl_ex_rns_if #(
  parameter int NUM_DOMAINS  = 2,
  parameter int PROG_CTR_WID = 10
);
  logic                             in_valid;
  logic                             in_ready;
  logic [2:0]                       op_sel;
  logic [NUM_DOMAINS-1:0][7:0]      op1;
  logic [NUM_DOMAINS-1:0][7:0]      op2;
  logic [7:0]                       imm;
  logic [2:0]                       res_addr;
  logic                             wr_en;
  logic [PROG_CTR_WID-1:0]          pred_nxt_prog_ctr;
  logic                             flush;
  logic                             out_valid;
  logic [NUM_DOMAINS-1:0][7:0]      operation_result;
  logic [2:0]                       destination_reg_addr;
  logic                             wr_en_ex;
  logic [PROG_CTR_WID-1:0]          pred_nxt_prog_ctr_EX;
  logic                             eq_flag;

  modport master (
    output in_valid, op_sel, op1, op2, imm, res_addr, wr_en, pred_nxt_prog_ctr, flush,
    input  in_ready, out_valid, operation_result, destination_reg_addr, wr_en_ex,
           pred_nxt_prog_ctr_EX, eq_flag
  );

  modport slave (
    input  in_valid, op_sel, op1, op2, imm, res_addr, wr_en, pred_nxt_prog_ctr, flush,
    output in_ready, out_valid, operation_result, destination_reg_addr, wr_en_ex,
           pred_nxt_prog_ctr_EX, eq_flag
  );
endinterface

// File: rtl/pl_ex_rns.sv
// RNS execute stage: single-cycle add/sub/ld_imm/pass, 8-iteration
// double-and-add modular multiply running all residue lanes in parallel.
module pl_ex_rns #(
  parameter int                       NUM_DOMAINS  = 2,
  parameter logic [NUM_DOMAINS*8-1:0] MODULI       = {8'd251, 8'd241},
  parameter int                       PROG_CTR_WID = 10
) (
  input  logic       clk,
  input  logic       reset,
  pl_ex_rns_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  logic [0:0]                  state_q;
  logic [2:0]                  cnt_q;
  logic [NUM_DOMAINS-1:0][7:0] a_q, b_q, acc_q, res_q;
  logic [NUM_DOMAINS-1:0][7:0] single_res, mac_res;
  logic                        out_valid_q, eq_q, wr_q, wr_h_q;
  logic [2:0]                  dst_q, dst_h_q;
  logic [PROG_CTR_WID-1:0]     pc_q, pc_h_q;
  logic                        in_ready, accept;

  assign in_ready = (state_q == IDLE) && !reset;
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_lane
    localparam logic [7:0] M8 = MODULI[g*8 +: 8];
    localparam logic [8:0] M  = {1'b0, M8};
    logic [7:0] a, b, imm_r, r;
    logic [8:0] add_s, diff, dbl, dbl_r, mac_s;

    assign a     = bus.op1[g];
    assign b     = bus.op2[g];
    assign add_s = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};
    assign imm_r = bus.imm % M8;

    always_comb begin
      r = '0;
      case (bus.op_sel)
        3'b000:  r = 8'((add_s >= M) ? add_s - M : add_s);
        3'b001:  r = 8'((a >= b) ? diff : diff + M);
        3'b011:  r = imm_r;
        3'b100:  r = a;
        default: r = '0;
      endcase
    end
    assign single_res[g] = r;

    // One multiply step: acc <- 2*acc + bit*a, each term reduced by one subtract.
    assign dbl        = {acc_q[g], 1'b0};
    assign dbl_r      = (dbl >= M) ? dbl - M : dbl;
    assign mac_s      = dbl_r + (b_q[g][7] ? {1'b0, a_q[g]} : 9'd0);
    assign mac_res[g] = 8'((mac_s >= M) ? mac_s - M : mac_s);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      eq_q        <= 1'b0;
      wr_q        <= 1'b0;
      wr_h_q      <= 1'b0;
      dst_q       <= '0;
      dst_h_q     <= '0;
      pc_q        <= '0;
      pc_h_q      <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (state_q == IDLE) begin
        if (accept && bus.op_sel == 3'b010) begin
          state_q <= MUL;
          cnt_q   <= '0;
          acc_q   <= '0;
          a_q     <= bus.op1;
          b_q     <= bus.op2;
          dst_h_q <= bus.res_addr;
          wr_h_q  <= bus.wr_en;
          pc_h_q  <= bus.pred_nxt_prog_ctr;
        end else if (accept) begin
          out_valid_q <= 1'b1;
          res_q       <= single_res;
          eq_q        <= (single_res == '0);
          dst_q       <= bus.res_addr;
          wr_q        <= bus.wr_en;
          pc_q        <= bus.pred_nxt_prog_ctr;
        end
      end else if (bus.flush) begin
        state_q <= IDLE;
      end else begin
        acc_q <= mac_res;
        for (int i = 0; i < NUM_DOMAINS; i++) b_q[i] <= {b_q[i][6:0], 1'b0};
        cnt_q <= cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b1;
          res_q       <= mac_res;
          eq_q        <= (mac_res == '0);
          dst_q       <= dst_h_q;
          wr_q        <= wr_h_q;
          pc_q        <= pc_h_q;
        end
      end
    end
  end

  assign bus.in_ready             = in_ready;
  assign bus.out_valid            = out_valid_q;
  assign bus.operation_result     = res_q;
  assign bus.eq_flag              = eq_q;
  assign bus.destination_reg_addr = dst_q;
  assign bus.wr_en_ex             = wr_q;
  assign bus.pred_nxt_prog_ctr_EX = pc_q;
endmodule

// File: tb/tb_pl_ex_rns.sv
// Directed bench for pl_ex_rns with moduli {251,241}.
module tb_pl_ex_rns;
  localparam int ND = 2;
  localparam int PW = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pl_ex_rns_if #(.NUM_DOMAINS(ND), .PROG_CTR_WID(PW)) bus ();

  pl_ex_rns #(.NUM_DOMAINS(ND), .MODULI({8'd251, 8'd241}), .PROG_CTR_WID(PW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] res, input logic eq);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    chk({tag, "_res"}, {16'd0, bus.operation_result}, {16'd0, res});
    chk({tag, "_eq"}, {31'd0, bus.eq_flag}, {31'd0, eq});
  endtask

  task automatic chk_side(input string tag, input logic [2:0] dst, input logic wr, input logic [PW-1:0] pc);
    chk({tag, "_dst"}, {29'd0, bus.destination_reg_addr}, {29'd0, dst});
    chk({tag, "_wr"}, {31'd0, bus.wr_en_ex}, {31'd0, wr});
    chk({tag, "_pc"}, {22'd0, bus.pred_nxt_prog_ctr_EX}, {22'd0, pc});
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [7:0] imm, input logic [2:0] addr, input logic wr,
                       input logic [PW-1:0] pc);
    bus.in_valid          = 1'b1;
    bus.op_sel            = op;
    bus.op1               = a;
    bus.op2               = b;
    bus.imm               = imm;
    bus.res_addr          = addr;
    bus.wr_en             = wr;
    bus.pred_nxt_prog_ctr = pc;
  endtask

  logic [2:0]  bb_op  [4] = '{3'b000, 3'b001, 3'b000, 3'b001};
  logic [15:0] bb_a   [4] = '{16'h0102, 16'h0909, 16'h6464, 16'h0000};
  logic [15:0] bb_b   [4] = '{16'h0304, 16'h0203, 16'hC8C8, 16'h0000};
  logic [15:0] bb_exp [4] = '{16'h0406, 16'h0706, 16'h313B, 16'h0000};

  initial begin
    bus.in_valid = 1'b0; bus.op_sel = '0; bus.op1 = '0; bus.op2 = '0; bus.imm = '0;
    bus.res_addr = '0; bus.wr_en = 1'b0; bus.pred_nxt_prog_ctr = '0; bus.flush = 1'b0;

    // Reset state
    #3;
    chk_out("rst", 1'b0, 16'h0000, 1'b0);
    chk_side("rst", 3'd0, 1'b0, 10'd0);
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rel_ready", {31'd0, bus.in_ready}, 32'd1);

    // Add with wrap, then add to zero
    issue(3'b000, 16'hFAF0, 16'h0305, 8'h00, 3'd3, 1'b1, 10'h011);
    tick();
    chk_out("add1", 1'b1, 16'h0204, 1'b0);
    chk_side("add1", 3'd3, 1'b1, 10'h011);
    bus.in_valid = 1'b0;
    tick();
    chk_out("hold", 1'b0, 16'h0204, 1'b0);
    chk_side("hold", 3'd3, 1'b1, 10'h011);
    issue(3'b000, 16'h01F0, 16'hFA01, 8'h00, 3'd2, 1'b0, 10'h012);
    tick();
    chk_out("add0", 1'b1, 16'h0000, 1'b1);

    // Sub with borrow
    issue(3'b001, 16'h0500, 16'h0701, 8'h00, 3'd1, 1'b1, 10'h013);
    tick();
    chk_out("sub", 1'b1, 16'hF9F0, 1'b0);

    // Back-to-back single-cycle ops
    for (int i = 0; i < 4; i++) begin
      issue(bb_op[i], bb_a[i], bb_b[i], 8'h00, 3'(i + 1), 1'b1, PW'(i + 1));
      tick();
      chk_out("b2b", 1'b1, bb_exp[i], bb_exp[i] == 16'h0);
      chk_side("b2b", 3'(i + 1), 1'b1, PW'(i + 1));
    end
    bus.in_valid = 1'b0;

    // Multiply with an add held pending behind it
    issue(3'b010, 16'h1064, 16'h1003, 8'h00, 3'd6, 1'b0, 10'h155);
    tick();
    chk("mul_rdy0", {31'd0, bus.in_ready}, 32'd0);
    chk("mul_v0", {31'd0, bus.out_valid}, 32'd0);
    issue(3'b000, 16'h0101, 16'h0101, 8'h00, 3'd7, 1'b1, 10'h02A);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("mul_busy_rdy", {31'd0, bus.in_ready}, 32'd0);
      chk("mul_busy_v", {31'd0, bus.out_valid}, 32'd0);
    end
    tick();
    chk_out("mul", 1'b1, 16'h053B, 1'b0);
    chk_side("mul", 3'd6, 1'b0, 10'h155);
    chk("mul_rdy1", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk_out("post_mul_add", 1'b1, 16'h0202, 1'b0);
    chk_side("post_mul_add", 3'd7, 1'b1, 10'h02A);
    bus.in_valid = 1'b0;
    tick();
    chk("single_pulse", {31'd0, bus.out_valid}, 32'd0);

    // ld_imm, pass, reserved
    issue(3'b011, 16'h0000, 16'h0000, 8'hFF, 3'd1, 1'b1, 10'h020);
    tick();
    chk_out("ldimm", 1'b1, 16'h040E, 1'b0);
    issue(3'b100, 16'h0709, 16'h1111, 8'h00, 3'd2, 1'b1, 10'h021);
    tick();
    chk_out("pass", 1'b1, 16'h0709, 1'b0);
    issue(3'b111, 16'h0709, 16'h0102, 8'h55, 3'd3, 1'b1, 10'h022);
    tick();
    chk_out("rsvd", 1'b1, 16'h0000, 1'b1);

    // Flush with a single-cycle op presented: not accepted
    issue(3'b000, 16'h0101, 16'h0101, 8'h00, 3'd4, 1'b1, 10'h030);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk_out("flush_single", 1'b0, 16'h0000, 1'b1);

    // Flush three cycles after mul accept
    issue(3'b010, 16'h1064, 16'h1003, 8'h00, 3'd5, 1'b1, 10'h040);
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_rdy", {31'd0, bus.in_ready}, 32'd1);
    chk("flush_v", {31'd0, bus.out_valid}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("flush_quiet", {31'd0, bus.out_valid}, 32'd0);
    end
    issue(3'b000, 16'h0101, 16'h0101, 8'h00, 3'd5, 1'b1, 10'h041);
    tick();
    bus.in_valid = 1'b0;
    chk_out("flush_add", 1'b1, 16'h0202, 1'b0);

    // Flush coinciding with the mul completion edge
    issue(3'b010, 16'h1064, 16'h1003, 8'h00, 3'd6, 1'b1, 10'h050);
    tick();
    bus.in_valid = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk_out("flush_last", 1'b0, 16'h0202, 1'b0);
    chk("flush_last_rdy", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk("flush_last_quiet", {31'd0, bus.out_valid}, 32'd0);

    // Reset mid-mul, asserted between edges
    issue(3'b010, 16'h1064, 16'h1003, 8'h00, 3'd7, 1'b1, 10'h3FF);
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    #2;
    reset = 1'b1;
    #1;
    chk_out("rst_mid", 1'b0, 16'h0000, 1'b0);
    chk_side("rst_mid", 3'd0, 1'b0, 10'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_rel_rdy", {31'd0, bus.in_ready}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("rst_no_stale", {31'd0, bus.out_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
